// File: rtl/axi_mem_slave.sv
// AXI4 burst memory slave: byte-strobed INCR writes and pipelined reads over an
// inferred word memory, with independent write and read channel state machines.
module axi_mem_slave #(
    parameter int DATA_BITS      = 64,
    parameter int ADDR_BITS      = 32,
    parameter int MEM_DEPTH_BITS = 10
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   rst,
    input  logic [ADDR_BITS-1:0]   S_AXI_AWADDR,
    input  logic [7:0]             S_AXI_AWLEN,
    input  logic                   S_AXI_AWVALID,
    output logic                   S_AXI_AWREADY,
    input  logic [DATA_BITS-1:0]   S_AXI_WDATA,
    input  logic [DATA_BITS/8-1:0] S_AXI_WSTRB,
    input  logic                   S_AXI_WLAST,
    input  logic                   S_AXI_WVALID,
    output logic                   S_AXI_WREADY,
    output logic [1:0]             S_AXI_BRESP,
    output logic                   S_AXI_BVALID,
    input  logic                   S_AXI_BREADY,
    input  logic [ADDR_BITS-1:0]   S_AXI_ARADDR,
    input  logic [7:0]             S_AXI_ARLEN,
    input  logic                   S_AXI_ARVALID,
    output logic                   S_AXI_ARREADY,
    output logic [DATA_BITS-1:0]   S_AXI_RDATA,
    output logic [1:0]             S_AXI_RRESP,
    output logic                   S_AXI_RLAST,
    output logic                   S_AXI_RVALID,
    input  logic                   S_AXI_RREADY
);
    localparam int STRB_BITS = DATA_BITS / 8;
    localparam int OFF       = $clog2(STRB_BITS);
    localparam int DEPTH     = 1 << MEM_DEPTH_BITS;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    w_state_t                  w_state_reg;
    logic [MEM_DEPTH_BITS-1:0] w_idx_reg;
    logic [7:0]                w_len_reg;
    logic [7:0]                w_beat_reg;
    logic                      w_err_reg;
    logic                      awready_reg;
    logic                      wready_reg;
    logic                      bvalid_reg;
    logic [1:0]                bresp_reg;

    r_state_t                  r_state_reg;
    logic [MEM_DEPTH_BITS-1:0] r_idx_reg;
    logic [7:0]                r_len_reg;
    logic [7:0]                r_beat_reg;
    logic                      arready_reg;
    logic                      rvalid_reg;
    logic                      rlast_reg;

    logic w_fire;
    logic w_final;
    logic w_beat_err;
    logic rd_en;
    logic unused_addr_bits;

    // wready is only ever high in W_DATA, so a fire is always a legal beat
    assign w_fire     = wready_reg & S_AXI_WVALID;
    assign w_final    = (w_beat_reg == w_len_reg);
    assign w_beat_err = S_AXI_WLAST ^ w_final;

    // Fetch the first word, then prefetch the next one whenever a non-last beat retires
    assign rd_en = (r_state_reg == R_FETCH) | (rvalid_reg & S_AXI_RREADY & ~rlast_reg);

    assign unused_addr_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR};

    always_ff @(posedge S_AXI_ACLK or posedge rst) begin
        if (rst) begin
            w_state_reg <= W_IDLE;
            w_idx_reg   <= '0;
            w_len_reg   <= '0;
            w_beat_reg  <= '0;
            w_err_reg   <= 1'b0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= 2'b00;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (S_AXI_AWVALID && awready_reg) begin
                        w_idx_reg   <= S_AXI_AWADDR[MEM_DEPTH_BITS+OFF-1:OFF];
                        w_len_reg   <= S_AXI_AWLEN;
                        w_beat_reg  <= '0;
                        w_err_reg   <= 1'b0;
                        awready_reg <= 1'b0;
                        wready_reg  <= 1'b1;
                        w_state_reg <= W_DATA;
                    end else begin
                        awready_reg <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_idx_reg  <= w_idx_reg + MEM_DEPTH_BITS'(1);
                        w_beat_reg <= w_beat_reg + 8'd1;
                        w_err_reg  <= w_err_reg | w_beat_err;
                        // The beat count, not WLAST, decides where the burst ends
                        if (w_final) begin
                            wready_reg  <= 1'b0;
                            bvalid_reg  <= 1'b1;
                            bresp_reg   <= (w_err_reg | w_beat_err) ? 2'b10 : 2'b00;
                            w_state_reg <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_reg  <= 1'b0;
                        bresp_reg   <= 2'b00;
                        awready_reg <= 1'b1;
                        w_state_reg <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge rst) begin
        if (rst) begin
            r_state_reg <= R_IDLE;
            r_idx_reg   <= '0;
            r_len_reg   <= '0;
            r_beat_reg  <= '0;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rlast_reg   <= 1'b0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (S_AXI_ARVALID && arready_reg) begin
                        r_idx_reg   <= S_AXI_ARADDR[MEM_DEPTH_BITS+OFF-1:OFF];
                        r_len_reg   <= S_AXI_ARLEN;
                        r_beat_reg  <= '0;
                        arready_reg <= 1'b0;
                        r_state_reg <= R_FETCH;
                    end else begin
                        arready_reg <= 1'b1;
                    end
                end
                R_FETCH: begin
                    r_idx_reg   <= r_idx_reg + MEM_DEPTH_BITS'(1);
                    rvalid_reg  <= 1'b1;
                    rlast_reg   <= (r_len_reg == 8'd0);
                    r_state_reg <= R_DATA;
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (rlast_reg) begin
                            rvalid_reg  <= 1'b0;
                            rlast_reg   <= 1'b0;
                            arready_reg <= 1'b1;
                            r_state_reg <= R_IDLE;
                        end else begin
                            r_idx_reg  <= r_idx_reg + MEM_DEPTH_BITS'(1);
                            r_beat_reg <= r_beat_reg + 8'd1;
                            rlast_reg  <= ((r_beat_reg + 8'd1) == r_len_reg);
                        end
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    // One memory per byte lane so each strobe bit maps onto its own write enable
    genvar gi;
    generate
        for (gi = 0; gi < STRB_BITS; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_q_reg;

            always_ff @(posedge S_AXI_ACLK) begin
                if (w_fire && S_AXI_WSTRB[gi]) begin
                    lane_mem[w_idx_reg] <= S_AXI_WDATA[gi*8 +: 8];
                end
            end

            always_ff @(posedge S_AXI_ACLK or posedge rst) begin
                if (rst) begin
                    lane_q_reg <= '0;
                end else if (rd_en) begin
                    lane_q_reg <= lane_mem[r_idx_reg];
                end
            end

            assign S_AXI_RDATA[gi*8 +: 8] = lane_q_reg;
        end
    endgenerate

    assign S_AXI_AWREADY = awready_reg;
    assign S_AXI_WREADY  = wready_reg;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_BRESP   = bresp_reg;
    assign S_AXI_ARREADY = arready_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RLAST   = rlast_reg;
    assign S_AXI_RRESP   = 2'b00;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomized bench for axi_mem_slave: a word-array model tracks every accepted write
// beat and predicts read data, write responses and read timing on every cycle.
module tb_axi_mem_slave;
    localparam int DB    = 64;
    localparam int AB    = 32;
    localparam int MDB   = 10;
    localparam int DEPTH = 1 << MDB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AB-1:0] S_AXI_AWADDR = '0;
    logic [7:0]    S_AXI_AWLEN = '0;
    logic          S_AXI_AWVALID = 1'b0;
    logic          S_AXI_AWREADY;
    logic [DB-1:0] S_AXI_WDATA = '0;
    logic [7:0]    S_AXI_WSTRB = '0;
    logic          S_AXI_WLAST = 1'b0;
    logic          S_AXI_WVALID = 1'b0;
    logic          S_AXI_WREADY;
    logic [1:0]    S_AXI_BRESP;
    logic          S_AXI_BVALID;
    logic          S_AXI_BREADY = 1'b0;
    logic [AB-1:0] S_AXI_ARADDR = '0;
    logic [7:0]    S_AXI_ARLEN = '0;
    logic          S_AXI_ARVALID = 1'b0;
    logic          S_AXI_ARREADY;
    logic [DB-1:0] S_AXI_RDATA;
    logic [1:0]    S_AXI_RRESP;
    logic          S_AXI_RLAST;
    logic          S_AXI_RVALID;
    logic          S_AXI_RREADY = 1'b0;

    always #5 clk = ~clk;

    axi_mem_slave #(.DATA_BITS(DB), .ADDR_BITS(AB), .MEM_DEPTH_BITS(MDB)) dut (
        .S_AXI_ACLK(clk), .rst(rst),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: no handshake within cycle budget", name);
    endfunction

    // Behavioural model: a plain word array plus queues of predicted responses
    logic [63:0] model_mem [DEPTH];
    logic [63:0] exp_r [$];
    logic [1:0]  exp_b [$];
    int          m_widx, m_wlen, m_wbeat, m_ridx, m_rlen;
    bit          m_werr, m_wactive;
    int          cyc = 0;
    int          ar_cyc = 0;
    bit          r_wait = 1'b0;
    bit          prev_rv = 1'b0, prev_rr = 1'b0, prev_rl = 1'b0;
    logic [63:0] prev_rd = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_wactive = 1'b0;
            r_wait    = 1'b0;
            prev_rv   = 1'b0;
            exp_r.delete();
            exp_b.delete();
        end else begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                m_widx    = int'((S_AXI_AWADDR / 32'd8) % 32'(DEPTH));
                m_wlen    = int'(S_AXI_AWLEN);
                m_wbeat   = 0;
                m_werr    = 1'b0;
                m_wactive = 1'b1;
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                check("w_burst_open", m_wactive, 1'b1);
                if (m_wactive) begin
                    for (int b = 0; b < 8; b++)
                        if (S_AXI_WSTRB[b]) model_mem[m_widx][b*8 +: 8] = S_AXI_WDATA[b*8 +: 8];
                    if (S_AXI_WLAST != (m_wbeat == m_wlen)) m_werr = 1'b1;
                    if (m_wbeat == m_wlen) begin
                        exp_b.push_back(m_werr ? 2'b10 : 2'b00);
                        m_wactive = 1'b0;
                    end
                    m_widx  = (m_widx + 1) % DEPTH;
                    m_wbeat = m_wbeat + 1;
                end
            end
            if (S_AXI_BVALID) begin
                if (exp_b.size() == 0) check("b_spurious", S_AXI_BVALID, 1'b0);
                else if (S_AXI_BREADY) check("bresp", S_AXI_BRESP, exp_b.pop_front());
            end
            if (r_wait && (S_AXI_RVALID || (cyc - ar_cyc) >= 2)) begin
                check("rvalid_latency", S_AXI_RVALID ? 64'(cyc - ar_cyc) : 64'd99, 64'd2);
                r_wait = 1'b0;
            end
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                m_ridx = int'((S_AXI_ARADDR / 32'd8) % 32'(DEPTH));
                m_rlen = int'(S_AXI_ARLEN);
                for (int i = 0; i <= m_rlen; i++) exp_r.push_back(model_mem[(m_ridx + i) % DEPTH]);
                ar_cyc = cyc;
                r_wait = 1'b1;
            end
            if (prev_rv && !prev_rr) begin
                check("r_hold_valid", S_AXI_RVALID, 1'b1);
                check("r_hold_data", S_AXI_RDATA, prev_rd);
                check("r_hold_last", S_AXI_RLAST, prev_rl);
            end
            if (S_AXI_RVALID) begin
                check("rresp", S_AXI_RRESP, 2'b00);
                if (exp_r.size() == 0) check("r_spurious", S_AXI_RVALID, 1'b0);
                else if (S_AXI_RREADY) begin
                    check("rdata", S_AXI_RDATA, exp_r[0]);
                    check("rlast", S_AXI_RLAST, exp_r.size() == 1);
                    void'(exp_r.pop_front());
                end
            end
            prev_rv = S_AXI_RVALID;
            prev_rr = S_AXI_RREADY;
            prev_rl = S_AXI_RLAST;
            prev_rd = S_AXI_RDATA;
        end
    end

    logic [63:0] rd_beats [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random upper and low address bits exercise aliasing and sub-word offsets
    function automatic logic [31:0] addr_of(input int idx);
        logic [31:0] a;
        a = $urandom;
        a[12:3] = idx[9:0];
        return a;
    endfunction

    task automatic do_write(input int idx, input int len, input int last_at, input bit use_fixed,
                            input logic [63:0] fixed, input logic [7:0] strb, input bit rand_strb,
                            output logic [1:0] resp);
        int beat;
        int t;
        resp = 2'bxx;
        S_AXI_AWADDR  = addr_of(idx);
        S_AXI_AWLEN   = 8'(len);
        S_AXI_AWVALID = 1'b1;
        t = 0;
        @(negedge clk);
        while (!S_AXI_AWREADY && t < 50) begin @(negedge clk); t++; end
        tick();
        S_AXI_AWVALID = 1'b0;
        if (t >= 50) begin timeout_fail("aw_handshake"); return; end
        beat = 0;
        t = 0;
        while (beat <= len && t < 2000) begin
            if ($urandom_range(0, 3) == 0) S_AXI_WVALID = 1'b0;
            else begin
                S_AXI_WVALID = 1'b1;
                S_AXI_WDATA  = use_fixed ? fixed + 64'(beat) : {$urandom, $urandom};
                S_AXI_WSTRB  = rand_strb ? 8'($urandom) : strb;
                S_AXI_WLAST  = (beat == last_at);
            end
            @(negedge clk);
            if (S_AXI_WVALID && S_AXI_WREADY) beat++;
            tick();
            t++;
        end
        S_AXI_WVALID = 1'b0;
        S_AXI_WLAST  = 1'b0;
        if (beat <= len) begin timeout_fail("w_beats"); return; end
        t = 0;
        @(negedge clk);
        while (!S_AXI_BVALID && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin timeout_fail("b_valid"); return; end
        repeat ($urandom_range(1, 3)) tick();
        S_AXI_BREADY = 1'b1;
        @(negedge clk);
        resp = S_AXI_BRESP;
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic do_read(input int idx, input int len, input bit rand_rdy);
        int t;
        bit done;
        rd_beats.delete();
        S_AXI_ARADDR  = addr_of(idx);
        S_AXI_ARLEN   = 8'(len);
        S_AXI_ARVALID = 1'b1;
        t = 0;
        @(negedge clk);
        while (!S_AXI_ARREADY && t < 50) begin @(negedge clk); t++; end
        tick();
        S_AXI_ARVALID = 1'b0;
        if (t >= 50) begin timeout_fail("ar_handshake"); return; end
        done = 1'b0;
        t = 0;
        while (!done && t < 2000) begin
            S_AXI_RREADY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                rd_beats.push_back(S_AXI_RDATA);
                done = S_AXI_RLAST;
            end
            tick();
            t++;
        end
        S_AXI_RREADY = 1'b0;
        if (!done) timeout_fail("r_last");
        check("r_beats_left", 64'(exp_r.size()), 64'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] resp;
        int idx, len, last_at;
        logic [63:0] base;

        #2 rst = 1'b1;
        #1;
        check("rst_awready", S_AXI_AWREADY, 1'b0);
        check("rst_arready", S_AXI_ARREADY, 1'b0);
        check("rst_wready", S_AXI_WREADY, 1'b0);
        check("rst_bvalid", S_AXI_BVALID, 1'b0);
        check("rst_rvalid", S_AXI_RVALID, 1'b0);
        check("rst_rlast", S_AXI_RLAST, 1'b0);
        check("rst_rdata", S_AXI_RDATA, 64'd0);
        check("rst_bresp", S_AXI_BRESP, 2'b00);
        check("rst_rresp", S_AXI_RRESP, 2'b00);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rel_awready", S_AXI_AWREADY, 1'b1);
        check("rel_arready", S_AXI_ARREADY, 1'b1);

        for (int k = 0; k < 4; k++) do_write(k * 256, 255, 255, 1'b0, 64'd0, 8'hFF, 1'b0, resp);

        base = 64'h0123_4567_89AB_CDE0;
        do_write(32, 3, 3, 1'b1, base, 8'hFF, 1'b0, resp);
        check("burst4_bresp", resp, 2'b00);
        do_read(32, 3, 1'b0);
        check("burst4_count", 64'(rd_beats.size()), 64'd4);
        for (int i = 0; i < 4; i++) check("burst4_data", rd_beats[i], base + 64'(i));

        do_write(50, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, resp);
        do_write(50, 0, 0, 1'b1, 64'h0, 8'h0F, 1'b0, resp);
        do_read(50, 0, 1'b0);
        check("strobe_merge", rd_beats[0], 64'hFFFF_FFFF_0000_0000);

        do_write(60, 1, 0, 1'b1, 64'hDEAD_0000_0000_0000, 8'hFF, 1'b0, resp);
        check("early_last_bresp", resp, 2'b10);
        do_read(60, 2, 1'b0);
        check("early_last_w0", rd_beats[0], 64'hDEAD_0000_0000_0000);
        check("early_last_w1", rd_beats[1], 64'hDEAD_0000_0000_0001);

        do_read(200, 15, 1'b1);
        check("stall_count", 64'(rd_beats.size()), 64'd16);

        do_write(1023, 3, 3, 1'b1, 64'hC0DE_0000_0000_0000, 8'hFF, 1'b0, resp);
        check("wrap_bresp", resp, 2'b00);
        do_read(1023, 3, 1'b1);
        for (int i = 0; i < 4; i++) check("wrap_data", rd_beats[i], 64'hC0DE_0000_0000_0000 + 64'(i));
        do_read(1, 0, 1'b0);
        check("wrap_idx1", rd_beats[0], 64'hC0DE_0000_0000_0002);

        for (int k = 0; k < 60; k++) begin
            idx = int'($urandom_range(0, DEPTH - 1));
            len = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                last_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : len;
                do_write(idx, len, last_at, 1'b0, 64'd0, 8'hFF, 1'b1, resp);
            end else begin
                do_read(idx, len, 1'($urandom_range(0, 1)));
            end
        end

        // Abandon a write burst part-way through with a reset pulse
        S_AXI_AWADDR  = addr_of(400);
        S_AXI_AWLEN   = 8'd7;
        S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b1;
        S_AXI_WSTRB   = 8'hFF;
        S_AXI_WLAST   = 1'b0;
        S_AXI_WDATA   = {$urandom, $urandom};
        tick();
        S_AXI_WDATA   = {$urandom, $urandom};
        tick();
        check("pre_rst_wready", S_AXI_WREADY, 1'b1);
        S_AXI_WVALID = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_wready", S_AXI_WREADY, 1'b0);
        check("mid_rst_bvalid", S_AXI_BVALID, 1'b0);
        check("mid_rst_awready", S_AXI_AWREADY, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_awready", S_AXI_AWREADY, 1'b1);
        check("post_rst_arready", S_AXI_ARREADY, 1'b1);
        check("post_rst_bvalid", S_AXI_BVALID, 1'b0);

        do_write(400, 7, 7, 1'b0, 64'd0, 8'hFF, 1'b1, resp);
        check("post_rst_bresp", resp, 2'b00);
        do_read(398, 11, 1'b1);
        check("post_rst_count", 64'(rd_beats.size()), 64'd12);

        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
